mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: AW, default 8, word-address width of the attached data memory (depth 2^AW words of 32 bits).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 req_signed  input  1  load sign-extension enable, ignored for stores.
REQ-009 req_addr  input  32  byte address; bits above AW+1 ignored.
REQ-010 req_wdata  input  32  store data, right-justified for byte and halfword.
REQ-011 resp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-012 resp_rdata  output  32  load result, valid with resp_valid; 0 for stores.
REQ-013 resp_err  output  1  misalignment flag, valid with resp_valid.
REQ-014 mem_a  output  AW  word index, equal to addr[AW+1:2].
REQ-015 mem_din  output  32  write data to memory.
REQ-016 mem_dout  input  32  combinational read data from memory.
REQ-017 mem_mread, mem_mwrite  output  1 each  memory read strobe and write strobe; memory writes on the posedge where mem_mwrite=1.

Function
REQ-018 FSM states are IDLE, RD, WR, RESP; a request is accepted on a posedge with req_valid=1 and req_ready=1, and all request fields are latched at that edge.
REQ-019 Loads use the path IDLE->RD->RESP. In RD, mem_mread=1 and mem_dout is captured and extracted. resp_valid is high the second cycle after the accept edge.
REQ-020 Word stores use the path IDLE->WR->RESP. In WR, mem_mwrite=1 and mem_din=wdata. resp_valid is high the second cycle after accept.
REQ-021 Byte and halfword stores use the path IDLE->RD->WR->RESP (read-modify-write). RD captures the old word. WR writes the old word with only the addressed lanes replaced. resp_valid is high the third cycle after accept.
REQ-022 Lanes are little-endian: byte k occupies bits [8k+7:8k], and halfword h occupies bits [16h+15:16h].
REQ-023 Byte and halfword loads are right-justified. They are zero-extended when req_signed=0 and sign-extended from the top loaded bit when req_signed=1.
REQ-024 RESP lasts exactly one cycle and then returns to IDLE. req_ready=1 in the cycle after resp_valid. Maximum throughput is one load or word store per 3 cycles.
REQ-025 mem_a is held constant from the accept edge through the end of WR, so RD and WR of one RMW address the same word.
REQ-026 mem_mwrite is asserted at most one cycle per store and never for loads; mem_mread is asserted only in RD.
REQ-027 Requests presented while req_ready=0 are ignored and have no side effects.
REQ-028 A misaligned access is a halfword with addr[0]=1, or a word (or size 11) with addr[1:0]!=00; its handling is defined in Configuration.

Reset
REQ-029 While rst_n=0, regardless of clk:
  - FSM is in IDLE and req_ready=1.
  - resp_valid, resp_rdata, resp_err, mem_mread, mem_mwrite, mem_a and mem_din are 0.
REQ-030 Reset asserted in RD or WR aborts the operation. No memory write occurs after the reset edge, and no response is issued for the aborted request.

Configuration
REQ-031 Macro MEM_ACCESS_MISALIGN_TRAP_EN:
  - Defined: a misaligned request goes IDLE->RESP with resp_err=1 and resp_rdata=0, so resp_valid is high the cycle after accept. Memory strobes stay 0.
  - Undefined: misaligned addresses are force-aligned (halfword clears addr[0]; word clears addr[1:0]), the access proceeds normally, and resp_err is tied to 0.

Verification
REQ-032 Memory word 5 = 0x8877_6655; load byte at addr 0x17 with signed=1 -> resp_rdata=0xFFFF_FF88 two cycles after accept; with signed=0 -> 0x0000_0088.
REQ-033 Memory word 5 = 0x8877_6655; store halfword 0x1234 at addr 0x14 -> exactly one mem_mwrite pulse, word 5 becomes 0x8877_1234, resp_valid three cycles after accept.
REQ-034 Store word 0xDEAD_BEEF at addr 0x3FC with AW=8 -> mem_a=255, word 255=0xDEAD_BEEF, resp_valid two cycles after accept; req_valid held high during busy cycles causes no second access.
REQ-035 Load word at addr 0x22 -> with macro defined: resp_err=1 and resp_rdata=0 one cycle after accept, no strobes; without the macro: word 8 is returned and resp_err=0.
REQ-036 rst_n pulsed low during WR of a byte store -> no write to memory, no resp_valid, req_ready=1 while reset is asserted, and the next load completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between a request port and a 32-bit word memory; sub-word stores use
// read-modify-write. Build option MEM_ACCESS_MISALIGN_TRAP_EN traps misaligned requests.
module mem_access_unit #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_dout,
  output logic          mem_mread,
  output logic          mem_mwrite
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e        state_q, state_d;
  logic          we_q, signed_q, err_q;
  logic [1:0]    size_q, off_q;
  logic [AW-1:0] a_q;
  logic [31:0]   wdata_q, word_q, rdata_q;

  logic          accept, trap;
  logic [1:0]    off_in;
  logic [31:0]   shifted, load_val, merged;
  logic          unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];
  assign accept      = req_valid && (state_q == StIdle);

  // Force-aligned byte offset; halfwords drop bit 0, words drop both bits.
  always_comb begin
    unique case (req_size)
      2'b00:   off_in = req_addr[1:0];
      2'b01:   off_in = {req_addr[1], 1'b0};
      default: off_in = 2'b00;
    endcase
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign trap = ((req_size == 2'b01) && req_addr[0]) ||
                (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (trap)                     state_d = StResp;
          else if (req_we && req_size[1]) state_d = StWr;
          else                          state_d = StRd;
        end
      end
      StRd:    state_d = we_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Load extraction straight from the combinational memory output.
  always_comb begin
    shifted = mem_dout >> {off_q, 3'b000};
    unique case (size_q)
      2'b00:   load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: load_val = mem_dout;
    endcase
  end

  // Replace only the addressed lanes of the word captured in RD.
  always_comb begin
    merged = word_q;
    unique case (size_q)
      2'b00:   merged[{off_q, 3'b000} +: 8]         = wdata_q[7:0];
      2'b01:   merged[{off_q[1], 4'b0000} +: 16]    = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      off_q    <= 2'b00;
      a_q      <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        err_q    <= trap;
        size_q   <= req_size;
        off_q    <= off_in;
        a_q      <= req_addr[AW+1:2];
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
      end
      if (state_q == StRd) begin
        word_q <= mem_dout;
        if (!we_q) rdata_q <= load_val;
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign mem_mread  = (state_q == StRd);
  assign mem_mwrite = (state_q == StWr);
  assign mem_a      = a_q;
  assign mem_din    = (state_q == StWr) ? merged : 32'h0;
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = (state_q == StResp) ? rdata_q : 32'h0;
  assign resp_err   = (state_q == StResp) && err_q;

endmodule
